conv_out_collector: RTL and testbench
=====================================

CONV_OUT_COLLECTOR -- requirements
Module: conv_out_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel width in bits, two's-complement.
REQ-002 Parameter IMG_WIDTH, default 28, input image edge; output frame edge OUT_DIM = IMG_WIDTH-2 (26), frame size OUT_DIM*OUT_DIM (676).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  convolution output pixel valid (driven from conv valid_out).
REQ-006 in_data  input  DATA_WIDTH  signed convolution output pixel (from conv pixel_out).
REQ-007 in_ready  output  1  collector accepting pixels (COLLECT state).
REQ-008 m_valid  output  1  drained pixel valid.
REQ-009 m_ready  input  1  downstream accepts drained pixel.
REQ-010 m_data  output  DATA_WIDTH  signed drained pixel.
REQ-011 m_eol  output  1  m_data is last pixel of a row (column OUT_DIM-1).
REQ-012 m_last  output  1  m_data is last pixel of frame (index 675).
REQ-013 frame_done  output  1  one-cycle pulse after final drain handshake.
REQ-014 drop_err  output  1  sticky: a pixel arrived while in_ready=0.

Function
REQ-015 Internal frame buffer SHALL hold OUT_DIM*OUT_DIM words of DATA_WIDTH, raster order, single clock.
REQ-016 Two states SHALL exist: COLLECT and DRAIN; reset state COLLECT.
REQ-017 COLLECT: in_ready=1, m_valid=0; each edge with in_valid=1 writes in_data at wr_addr, wr_addr increments.
REQ-018 in_valid gaps of any length SHALL be tolerated; no write on in_valid=0.
REQ-019 Write at wr_addr=675 SHALL move state to DRAIN on the same edge, wr_addr to 0, in_ready=0 from next cycle.
REQ-020 DRAIN: first m_valid=1 SHALL appear exactly one cycle after entering DRAIN, carrying pixel 0.
REQ-021 Handshake = m_valid&&m_ready at rising edge; on handshake, next pixel SHALL be presented the following cycle (no bubble), giving 1 pixel/cycle when m_ready held high.
REQ-022 While m_valid=1 and m_ready=0, m_data, m_eol, m_last SHALL hold stable.
REQ-023 m_eol=1 SHALL accompany indices where (index mod OUT_DIM)=OUT_DIM-1; m_last=1 only with index 675 (m_eol also 1 there).
REQ-024 Handshake on index 675: next cycle m_valid=0, in_ready=1, state COLLECT, frame_done=1 for exactly one cycle.
REQ-025 in_valid=1 while in_ready=0 (DRAIN): pixel SHALL be discarded, buffer and counters unchanged, drop_err set to 1 and held until rst.
REQ-026 m_data SHALL equal stored value bit-exactly; no saturation, sign change or truncation.
REQ-027 m_ready while m_valid=0 SHALL have no effect.
REQ-028 Throughput: one frame per 676 collect cycles plus 677 drain cycles minimum (m_ready=1).

Reset
REQ-029 rst=1 at an edge SHALL force: state COLLECT, wr_addr=0, read pointer=0, in_ready=1, m_valid=0, m_data=0, m_eol=0, m_last=0, frame_done=0, drop_err=0.
REQ-030 Reset mid-COLLECT or mid-DRAIN SHALL abandon the partial frame; buffer contents need not be cleared; next frame SHALL write from address 0.
REQ-031 rst dominates in_valid and m_ready in the same cycle.

Verification
REQ-032 Ramp: 676 pixels in_data=i[7:0], in_valid continuous, m_ready=1 -> m_data sequence 0..255,0..255,0..163 on 676 consecutive cycles starting 2 cycles after last write edge; m_eol at indices 25,51,...,675; m_last at 675; frame_done one cycle after.
REQ-033 Backpressure: m_ready alternating 1,0 and random -> every index drained exactly once, in order, m_data stable while stalled.
REQ-034 Input gaps: in_valid 50% random during ramp frame -> drained sequence identical to REQ-032.
REQ-035 Drop: in_valid=1, in_data=0x7F for 10 cycles during DRAIN -> drained frame unchanged, drop_err=1 until rst, in_ready=0 throughout.
REQ-036 Reset mid-drain after 100 handshakes -> next cycle m_valid=0, in_ready=1, drop_err=0; subsequent frame of all 0x80 (-128) drains as 676 x 0x80.
REQ-037 Two back-to-back frames (values 0x01 then 0xFF) -> two frame_done pulses; second frame drains all 0xFF, no first-frame data.

Source files
------------

// File: rtl/conv_out_collector.sv
// Collects one convolution output frame into a local buffer, then drains it in
// raster order over a valid/ready stream with row and frame markers.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_COLLECT | accepting pixels into the buffer, stream output idle
// S_DRAIN   | input closed, buffer streamed out one pixel per handshake
module conv_out_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [DATA_WIDTH-1:0] m_data,
  output logic                         m_eol,
  output logic                         m_last,
  output logic                         frame_done,
  output logic                         drop_err
);

  localparam int OUT_DIM = IMG_WIDTH - 2;
  localparam int FRAME   = OUT_DIM * OUT_DIM;
  localparam int AW      = $clog2(FRAME);
  localparam int CW      = $clog2(OUT_DIM);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(OUT_DIM - 1);

  typedef enum logic {S_COLLECT, S_DRAIN} state_t;

  state_t                        r_state;
  logic [DATA_WIDTH-1:0]         r_mem [FRAME];
  logic [AW-1:0]                 r_wr_addr;
  logic [AW-1:0]                 r_rd_addr;
  logic [CW-1:0]                 r_rd_col;
  logic                          r_in_ready;
  logic                          r_m_valid;
  logic signed [DATA_WIDTH-1:0]  r_m_data;
  logic                          r_m_eol;
  logic                          r_m_last;
  logic                          r_frame_done;
  logic                          r_drop_err;
  logic                          w_hs;
  logic                          w_wr_en;

  assign w_hs    = r_m_valid && m_ready;
  assign w_wr_en = (r_state == S_COLLECT) && in_valid;

  // Buffer is never cleared; a reset simply restarts writing at address 0.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      r_mem[r_wr_addr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_COLLECT;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_rd_col     <= '0;
      r_in_ready   <= 1'b1;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_eol      <= 1'b0;
      r_m_last     <= 1'b0;
      r_frame_done <= 1'b0;
      r_drop_err   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (in_valid && !r_in_ready) begin
        r_drop_err <= 1'b1;
      end
      case (r_state)
        S_COLLECT: begin
          if (in_valid) begin
            if (r_wr_addr == LAST_ADDR) begin
              r_wr_addr  <= '0;
              r_rd_addr  <= '0;
              r_rd_col   <= '0;
              r_in_ready <= 1'b0;
              r_state    <= S_DRAIN;
            end else begin
              r_wr_addr <= r_wr_addr + AW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_hs && r_m_last) begin
            r_m_valid    <= 1'b0;
            r_m_eol      <= 1'b0;
            r_m_last     <= 1'b0;
            r_in_ready   <= 1'b1;
            r_frame_done <= 1'b1;
            r_state      <= S_COLLECT;
          end else if (!r_m_valid || w_hs) begin
            // Empty output register (first cycle) or just consumed: load next word.
            r_m_valid <= 1'b1;
            r_m_data  <= r_mem[r_rd_addr];
            r_m_eol   <= (r_rd_col == LAST_COL);
            r_m_last  <= (r_rd_addr == LAST_ADDR);
            r_rd_addr <= (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + AW'(1);
            r_rd_col  <= (r_rd_col == LAST_COL) ? '0 : r_rd_col + CW'(1);
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_eol      = r_m_eol;
  assign m_last     = r_m_last;
  assign frame_done = r_frame_done;
  assign drop_err   = r_drop_err;

endmodule

// File: tb/tb_conv_out_collector.sv
// Randomized bench for conv_out_collector: each frame's pixels are kept in an
// array and every drained handshake is compared against index-derived rules.
module tb_conv_out_collector;

  localparam int DW    = 8;
  localparam int IMG   = 28;
  localparam int OD    = IMG - 2;
  localparam int FRAME = OD * OD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          m_ready = 1'b0;
  logic          in_ready, m_valid, m_eol, m_last, frame_done, drop_err;
  logic [DW-1:0] m_data;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_px [FRAME];
  logic          exp_drop = 1'b0;

  conv_out_collector #(.DATA_WIDTH(DW), .IMG_WIDTH(IMG)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_eol      (m_eol),
    .m_last     (m_last),
    .frame_done (frame_done),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // mode 0: ramp i[7:0], 1: random, 2: constant k
  task automatic fill(input int mode, input logic [DW-1:0] k);
    for (int i = 0; i < FRAME; i++) begin
      case (mode)
        0:       exp_px[i] = i[DW-1:0];
        1:       exp_px[i] = DW'($urandom);
        default: exp_px[i] = k;
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    m_ready  = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_eol", m_eol, 0);
    check("rst_m_last", m_last, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_drop_err", drop_err, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    m_ready  = 1'b0;
    exp_drop = 1'b0;
  endtask

  // Writes the first n pixels of exp_px with pct% valid density.
  task automatic load(input int pct, input int n);
    int i = 0;
    while (i < n) begin
      @(negedge clk);
      check("collect_in_ready", in_ready, 1);
      check("collect_m_valid", m_valid, 0);
      m_ready = 1'($urandom_range(1));
      if (int'($urandom_range(99)) < pct) begin
        in_valid = 1'b1;
        in_data  = exp_px[i];
        i++;
      end else begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
      end
    end
    if (n == FRAME) begin
      @(negedge clk);
      in_valid = 1'b0;
      m_ready  = 1'b1;
      check("enter_drain_in_ready", in_ready, 0);
      check("enter_drain_m_valid", m_valid, 0);
    end
  endtask

  // rmode 0: ready held high, 1: alternating 1,0, 2: random.
  task automatic drain(input int rmode, input int drops, input int stop_at);
    int idx = 0;
    int cyc = 0;
    while (idx < stop_at && cyc < 5000) begin
      @(negedge clk);
      check("drain_m_valid", m_valid, 1);
      check("drain_in_ready", in_ready, 0);
      check("drain_frame_done", frame_done, 0);
      check("drain_data", m_data, exp_px[idx]);
      check("drain_eol", m_eol, (idx % OD) == OD - 1);
      check("drain_last", m_last, idx == FRAME - 1);
      in_valid = (cyc < drops);
      in_data  = 8'h7F;
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 2) == 0;
        default: m_ready = 1'($urandom_range(1));
      endcase
      if (m_valid && m_ready) idx++;
      cyc++;
    end
    if (idx < stop_at) check("drain_timeout", idx, stop_at);
    if (drops > 0) exp_drop = 1'b1;
    if (rmode == 0 && stop_at == FRAME) check("drain_cycles", cyc, FRAME);
    if (stop_at == FRAME) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("done_pulse", frame_done, 1);
      check("done_m_valid", m_valid, 0);
      check("done_in_ready", in_ready, 1);
      check("drop_err", drop_err, exp_drop);
      m_ready = 1'($urandom_range(1));
      @(negedge clk);
      check("done_pulse_end", frame_done, 0);
      check("idle_m_valid", m_valid, 0);
    end
  endtask

  initial begin
    do_reset();
    fill(0, '0); load(100, FRAME); drain(0, 0, FRAME);
    fill(0, '0); load(100, FRAME); drain(1, 0, FRAME);
    fill(1, '0); load(70, FRAME);  drain(2, 0, FRAME);
    fill(0, '0); load(50, FRAME);  drain(0, 0, FRAME);
    fill(1, '0); load(100, FRAME); drain(2, 10, FRAME);
    fill(1, '0); load(60, FRAME);  drain(0, 0, FRAME);
    fill(1, '0); load(100, FRAME); drain(2, 5, 100);
    do_reset();
    fill(2, 8'h80); load(100, FRAME); drain(0, 0, FRAME);
    fill(1, '0); load(80, 300);
    do_reset();
    fill(2, 8'h01); load(100, FRAME); drain(0, 0, FRAME);
    fill(2, 8'hFF); load(100, FRAME); drain(2, 0, FRAME);
    for (int f = 0; f < 2; f++) begin
      fill(1, '0);
      load(int'($urandom_range(30, 100)), FRAME);
      drain(2, 0, FRAME);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
